// File: rtl/cpu_cen_ctrl.sv
// CPU clock-enable controller: fractional n/m enable, stall debt with paced
// replay, and vsync-aligned pause / turbo.
module cpu_cen_ctrl #(
    parameter int unsigned FRAC_W         = 10,
    parameter int unsigned DEBT_W         = 16,
    parameter int unsigned CATCHUP_GAP    = 0,
    parameter int unsigned FLUSH_ON_PAUSE = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [FRAC_W-1:0] cen_n,
    input  logic [FRAC_W-1:0] cen_m,
    input  logic              ready,
    input  logic              turbo,
    input  logic              pause_rq,
    input  logic              vsync,
    output logic              paused,
    output logic              ce_nom,
    output logic              ce_cpu,
    output logic [DEBT_W-1:0] debt,
    output logic              debt_sat
);

    localparam int unsigned ACC_W = FRAC_W + 1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned GAP_W = (CATCHUP_GAP > 0) ? $clog2(CATCHUP_GAP + 1) : 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ce_nom_q, ce_nom_d;
    logic [DEBT_W-1:0]  debt_q, debt_d;
    logic               debt_sat_q, debt_sat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [SUM_W-1:0]   sum;
    logic               paused_w;
    logic               pause_entry;
    logic               catchup;

    // State registers
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            acc_q      <= '0;
            ce_nom_q   <= 1'b0;
            debt_q     <= '0;
            debt_sat_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ce_nom_q   <= ce_nom_d;
            debt_q     <= debt_d;
            debt_sat_q <= debt_sat_d;
            gap_q      <= gap_d;
        end
    end

    // Divider, pause FSM, replay pacing and debt bookkeeping
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ce_nom_d    = 1'b0;
        debt_d      = debt_q;
        debt_sat_d  = debt_sat_q;
        gap_d       = gap_q;
        pause_entry = 1'b0;

        sum = SUM_W'(acc_q) + SUM_W'(cen_n);

        if (cen_m == '0) begin
            acc_d = '0;
        end else if (cen_n >= cen_m) begin
            ce_nom_d = 1'b1;
            acc_d    = '0;
        end else if (sum >= SUM_W'(cen_m)) begin
            ce_nom_d = 1'b1;
            acc_d    = ACC_W'(sum - SUM_W'(cen_m));
        end else begin
            acc_d = ACC_W'(sum);
        end

        // Pause is only entered inside vsync and only left outside it
        if (state_q == ST_RUN) begin
            if (pause_rq && vsync) begin
                state_d     = ST_PAUSED;
                pause_entry = 1'b1;
            end
        end else begin
            if (!pause_rq && !vsync) begin
                state_d = ST_RUN;
            end
        end

        paused_w = (state_q == ST_PAUSED);
        catchup  = ready && !ce_nom_q && !turbo && !paused_w
                   && (debt_q != '0) && (gap_q == '0);
        ce_cpu   = !paused_w && ready && (ce_nom_q || turbo || catchup);

        if (catchup) begin
            gap_d = GAP_W'(CATCHUP_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        // Debt priority: turbo, flush on pause entry, hold while paused, stall, replay
        if (turbo) begin
            debt_d = '0;
        end else if (pause_entry && (FLUSH_ON_PAUSE != 0)) begin
            debt_d = '0;
        end else if (paused_w) begin
            debt_d = debt_q;
        end else if (ce_nom_q && !ready) begin
            if (debt_q == '1) begin
                debt_sat_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_W'(1);
            end
        end else if (catchup) begin
            debt_d = debt_q - DEBT_W'(1);
        end
    end

    assign paused   = paused_w;
    assign ce_nom   = ce_nom_q;
    assign debt     = debt_q;
    assign debt_sat = debt_sat_q;

endmodule

// File: tb/tb_cpu_cen_ctrl.sv
// Directed bench for cpu_cen_ctrl: instance a (gap 0, 4-bit debt) and
// instance b (gap 3, 16-bit debt) share one stimulus stream.
module tb_cpu_cen_ctrl;

    logic        clk_sys;
    logic        reset_n;
    logic [9:0]  cen_n;
    logic [9:0]  cen_m;
    logic        ready;
    logic        turbo;
    logic        pause_rq;
    logic        vsync;

    logic        paused_a, ce_nom_a, ce_cpu_a, debt_sat_a;
    logic [3:0]  debt_a;
    logic        paused_b, ce_nom_b, ce_cpu_b, debt_sat_b;
    logic [15:0] debt_b;

    int checks   = 0;
    int failures = 0;
    int cnt_a, cnt_b, dbad, ones_a, perr, nrep;

    cpu_cen_ctrl #(.FRAC_W(10), .DEBT_W(4), .CATCHUP_GAP(0), .FLUSH_ON_PAUSE(1)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .cen_n(cen_n), .cen_m(cen_m),
        .ready(ready), .turbo(turbo), .pause_rq(pause_rq), .vsync(vsync),
        .paused(paused_a), .ce_nom(ce_nom_a), .ce_cpu(ce_cpu_a),
        .debt(debt_a), .debt_sat(debt_sat_a)
    );

    cpu_cen_ctrl #(.FRAC_W(10), .DEBT_W(16), .CATCHUP_GAP(3), .FLUSH_ON_PAUSE(1)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .cen_n(cen_n), .cen_m(cen_m),
        .ready(ready), .turbo(turbo), .pause_rq(pause_rq), .vsync(vsync),
        .paused(paused_b), .ce_nom(ce_nom_b), .ce_cpu(ce_cpu_b),
        .debt(debt_b), .debt_sat(debt_sat_b)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
    endtask

    // Cycles (counted from reset release) on which instance b replays, n=1 m=3 gap=3
    function automatic bit exp_rep_b(input int c);
        case (c)
            31, 35, 40, 44, 49, 53, 58, 62, 67, 71: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0; cen_n = 10'd1; cen_m = 10'd3;
        ready = 1'b1; turbo = 1'b0; pause_rq = 1'b0; vsync = 1'b0;

        // Reset state
        step(2);
        chk("rst_ce_nom", ce_nom_a, 0);
        chk("rst_paused", paused_a, 0);
        chk("rst_debt", debt_a, 0);
        chk("rst_debt_sat", debt_sat_a, 0);
        chk("rst_ce_cpu", ce_cpu_a, 0);
        turbo = 1'b1; #1;
        chk("rst_turbo_ce_cpu", ce_cpu_a, 1);
        turbo = 1'b0;
        reset_n = 1'b1;

        // Nominal rate 1/3: first pulse after the third edge
        step(1); chk("nom_c1", ce_nom_a, 0);
        step(1); chk("nom_c2", ce_nom_a, 0);
        step(1); chk("nom_c3", ce_nom_a, 1); chk("nom_c3_cpu", ce_cpu_a, 1);
        cnt_a = 1; cnt_b = 1; dbad = 0;
        for (int i = 4; i <= 300; i++) begin
            step(1);
            cnt_a += int'(ce_cpu_a);
            cnt_b += int'(ce_cpu_b);
            if (debt_a != 4'd0 || debt_b != 16'd0) dbad++;
        end
        chk("nom_1_3_cnt_a", cnt_a, 100);
        chk("nom_1_3_cnt_b", cnt_b, 100);
        chk("nom_1_3_debt", dbad, 0);

        // Nominal rate 9/20
        cen_n = 10'd9; cen_m = 10'd20;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            cnt_a += int'(ce_cpu_a);
            cnt_b += int'(ce_cpu_b);
        end
        chk("nom_9_20_cnt_a", cnt_a, 90);
        chk("nom_9_20_cnt_b", cnt_b, 90);

        // Stall for 31 edges: ten nominal pulses lost
        cen_n = 10'd1; cen_m = 10'd3; ready = 1'b0;
        do_reset();
        cnt_a = 0;
        for (int i = 0; i < 31; i++) begin
            step(1);
            cnt_a += int'(ce_cpu_a);
        end
        chk("stall_ce_cpu", cnt_a, 0);
        chk("stall_debt_a", debt_a, 10);
        chk("stall_debt_b", debt_b, 10);
        ready = 1'b1; #1;
        chk("replay_first", ce_cpu_a, 1);

        // Replay: a runs back-to-back, b paced every 4 cycles around ce_nom
        ones_a = 0; perr = 0; nrep = 0;
        for (int c = 31; c <= 75; c++) begin
            if (c <= 45) ones_a += int'(ce_cpu_a);
            if (c == 46) begin
                chk("replay_done_debt_a", debt_a, 0);
                chk("replay_done_ce_cpu", ce_cpu_a, 0);
            end
            if ((ce_cpu_b && !ce_nom_b) != exp_rep_b(c)) perr++;
            if (ce_cpu_b && !ce_nom_b) nrep++;
            step(1);
        end
        chk("replay_ones_a", ones_a, 15);
        chk("pace_pattern_b", perr, 0);
        chk("pace_count_b", nrep, 10);
        chk("pace_debt_b", debt_b, 0);

        // Saturation of the 4-bit debt counter
        ready = 1'b0;
        do_reset();
        step(46);
        chk("sat_edge_debt", debt_a, 15);
        chk("sat_edge_flag", debt_sat_a, 0);
        step(3);
        chk("sat_set_flag", debt_sat_a, 1);
        chk("sat_set_debt", debt_a, 15);
        step(12);
        chk("sat_hold_debt_a", debt_a, 15);
        chk("sat_debt_b", debt_b, 20);
        chk("sat_flag_b", debt_sat_b, 0);
        ready = 1'b1;
        step(40);
        chk("sat_drain_debt", debt_a, 0);
        chk("sat_sticky", debt_sat_a, 1);
        chk("pace_mid_debt_b", debt_b, 11);

        // Reset in the middle of b's replay
        reset_n = 1'b0;
        step(1);
        chk("mid_rst_debt_a", debt_a, 0);
        chk("mid_rst_sat_a", debt_sat_a, 0);
        chk("mid_rst_debt_b", debt_b, 0);
        chk("mid_rst_paused", paused_a, 0);
        chk("mid_rst_ce_nom", ce_nom_a, 0);
        reset_n = 1'b1;

        // Pause alignment and flush
        ready = 1'b0;
        do_reset();
        step(22);
        chk("pause_pre_debt", debt_a, 7);
        pause_rq = 1'b1;
        step(1);
        chk("pause_no_vsync", paused_a, 0);
        chk("pause_no_vsync_debt", debt_a, 7);
        vsync = 1'b1;
        step(1);
        ready = 1'b1; #1;
        chk("pause_enter", paused_a, 1);
        chk("pause_flush_a", debt_a, 0);
        chk("pause_flush_b", debt_b, 0);
        chk("pause_nom_running", ce_nom_a, 1);
        chk("pause_ce_cpu", ce_cpu_a, 0);
        pause_rq = 1'b0;
        step(1);
        chk("pause_hold_vsync", paused_a, 1);
        ready = 1'b0;
        step(3);
        chk("pause_no_debt", debt_a, 0);
        chk("pause_still", paused_a, 1);
        vsync = 1'b0;
        step(1);
        chk("pause_exit", paused_a, 0);
        chk("pause_exit_debt", debt_a, 0);

        // Turbo clears debt and follows ready
        ready = 1'b0;
        do_reset();
        step(16);
        chk("turbo_pre_debt", debt_a, 5);
        turbo = 1'b1; ready = 1'b1; #1;
        chk("turbo_ce_ready1", ce_cpu_a, 1);
        ready = 1'b0; #1;
        chk("turbo_ce_ready0", ce_cpu_a, 0);
        ready = 1'b1;
        step(1);
        chk("turbo_debt_clr", debt_a, 0);
        chk("turbo_ce_next", ce_cpu_a, 1);
        turbo = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
